// File: rtl/ulg_pkg.sv
// ULG encoder shared definitions: handshake states,
// output-grid pixel count helper and default widths.
package ulg_pkg;

  localparam int ULG_DATA_W = 8;
  localparam int ULG_IN_CH  = 8;

  typedef enum logic [1:0] {
    H_IDLE     = 2'd0,
    H_ACK      = 2'd1,
    H_WAIT_LOW = 2'd2
  } h_state_t;

  function automatic int calc_npix(
    input int img_w,
    input int img_h,
    input int k_dim
  );
    return (img_h - k_dim + 1) * (img_w - k_dim + 1);
  endfunction

endpackage

// File: rtl/ulg_enc_fifo.sv
// Show-ahead FIFO for processed pixels; head entry is
// always visible on o_data, occupancy on o_count.
module ulg_enc_fifo #(
  parameter  int WIDTH = 68,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [CW-1:0]    r_count;

  // Storage is cleared too so the head reads zero out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr] <= i_data;
        r_wr        <= r_wr + 1'b1;
      end
      if (i_pop) r_rd <= r_rd + 1'b1;
      unique case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd];
  assign o_count = r_count;

endmodule

// File: rtl/ulg_encoder.sv
// ULG encoder: req/ack capture, per-channel processing, argmax, FIFO.
// Define ULG_ENC_RELU_EN to clamp negative channels to zero.
module ulg_encoder
  import ulg_pkg::*;
#(
  parameter int DATA_W     = ULG_DATA_W,
  parameter int IN_CH      = ULG_IN_CH,
  parameter int K_DIM      = 3,
  parameter int IMG_W      = 5,
  parameter int IMG_H      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            i_clk_en,
  input  logic                            i_frame_start,
  input  logic                            i_encoder_req,
  output logic                            o_encoder_ack,
  input  logic signed [IN_CH*DATA_W-1:0]  i_encoder_data_flat,
  output logic                            o_out_valid,
  input  logic                            i_out_ready,
  output logic [IN_CH*DATA_W-1:0]         o_out_data,
  output logic [$clog2(IN_CH)-1:0]        o_out_argmax,
  output logic                            o_out_last,
  output logic                            o_frame_done
);

  localparam int DW   = IN_CH * DATA_W;
  localparam int AW   = $clog2(IN_CH);
  localparam int EW   = DW + AW + 1;
  localparam int CW   = $clog2(FIFO_DEPTH) + 1;
  localparam int NPIX = calc_npix(IMG_W, IMG_H, K_DIM);
  localparam int PW   = (NPIX > 1) ? $clog2(NPIX) : 1;

  h_state_t                 r_state;
  logic                     r_ack;
  logic                     r_stage_v;
  logic [DW-1:0]            r_stage_data;
  logic [PW-1:0]            r_pix;
  logic                     r_frame_done;

  logic [DW-1:0]            w_proc;
  logic [AW-1:0]            w_arg;
  logic signed [DATA_W-1:0] w_ch;
  logic signed [DATA_W-1:0] w_max;
  logic                     w_last;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_room;
  logic [CW-1:0]            w_count;
  logic [EW-1:0]            w_head;

  // Staged pixel counts against capacity so ack never outruns the FIFO
  assign w_room = (int'(w_count) + int'(r_stage_v)) < FIFO_DEPTH;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= H_IDLE;
      r_ack        <= 1'b0;
      r_stage_v    <= 1'b0;
      r_stage_data <= '0;
    end else if (i_clk_en) begin
      if (r_stage_v) r_stage_v <= 1'b0;
      unique case (r_state)
        H_IDLE: begin
          if (i_encoder_req && w_room) begin
            r_state      <= H_ACK;
            r_ack        <= 1'b1;
            r_stage_data <= i_encoder_data_flat;
            r_stage_v    <= 1'b1;
          end
        end
        H_ACK: begin
          r_ack   <= 1'b0;
          r_state <= H_WAIT_LOW;
        end
        H_WAIT_LOW: begin
          if (!i_encoder_req) r_state <= H_IDLE;
        end
        default: r_state <= H_IDLE;
      endcase
    end
  end

  always_comb begin
    w_proc = r_stage_data;
    w_arg  = '0;
    w_ch   = '0;
    w_max  = '0;
    for (int c = 0; c < IN_CH; c++) begin
      w_ch = r_stage_data[c*DATA_W +: DATA_W];
`ifdef ULG_ENC_RELU_EN
      if (w_ch < 0) w_ch = '0;
`endif
      w_proc[c*DATA_W +: DATA_W] = w_ch;
      // Strict compare keeps the lowest index on ties
      if (c == 0 || w_ch > w_max) begin
        w_max = w_ch;
        w_arg = AW'(c);
      end
    end
  end

  assign w_last = (r_pix == PW'(NPIX - 1));
  assign w_push = i_clk_en & r_stage_v;
  assign w_pop  = i_clk_en & o_out_valid & i_out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pix        <= '0;
      r_frame_done <= 1'b0;
    end else if (i_clk_en) begin
      if (i_frame_start)
        r_pix <= '0;
      else if (w_push)
        r_pix <= w_last ? '0 : r_pix + 1'b1;
      r_frame_done <= w_pop & w_head[EW-1];
    end
  end

  ulg_enc_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  ({w_last, w_arg, w_proc}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_count (w_count)
  );

  assign o_encoder_ack = r_ack;
  assign o_out_valid   = (w_count != '0);
  assign o_frame_done  = r_frame_done;
  assign {o_out_last, o_out_argmax, o_out_data} = w_head;

endmodule

// File: tb/tb_ulg_encoder.sv
// Directed bench for ulg_encoder: handshake, processing,
// backpressure, frame boundaries, clock enable and reset.
module tb_ulg_encoder;

  localparam int NP = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_clk_en = 1'b1;
  logic        i_frame_start = 1'b0;
  logic        i_encoder_req = 1'b0;
  logic        i_out_ready = 1'b1;
  logic signed [63:0] i_encoder_data_flat = '0;
  logic        o_encoder_ack;
  logic        o_out_valid;
  logic [63:0] o_out_data;
  logic [2:0]  o_out_argmax;
  logic        o_out_last;
  logic        o_frame_done;

  int n_checks = 0;
  int n_err = 0;
  int ack_rise = 0;
  int fd_cnt = 0;
  int exp_idx = 0;
  logic ack_q = 1'b0;
  logic [67:0] out_q[$];
  logic [67:0] exp_q[$];

  always #5 clk = ~clk;

  ulg_encoder dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .i_clk_en            (i_clk_en),
    .i_frame_start       (i_frame_start),
    .i_encoder_req       (i_encoder_req),
    .o_encoder_ack       (o_encoder_ack),
    .i_encoder_data_flat (i_encoder_data_flat),
    .o_out_valid         (o_out_valid),
    .i_out_ready         (i_out_ready),
    .o_out_data          (o_out_data),
    .o_out_argmax        (o_out_argmax),
    .o_out_last          (o_out_last),
    .o_frame_done        (o_frame_done)
  );

  // Observe one time unit before each rising edge
  always @(negedge clk) begin
    #4;
    if (o_encoder_ack && !ack_q) ack_rise++;
    ack_q = o_encoder_ack;
    if (o_frame_done && i_clk_en) fd_cnt++;
    if (o_out_valid && i_out_ready && i_clk_en && rst_n)
      out_q.push_back({o_out_last, o_out_argmax, o_out_data});
  end

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [67:0] model(input logic [63:0] flat,
                                        input bit last);
    logic signed [7:0] v;
    logic signed [7:0] mx;
    logic [2:0] a;
    logic [63:0] d;
    d = flat; mx = '0; a = '0;
    for (int c = 0; c < 8; c++) begin
      v = flat[c*8 +: 8];
`ifdef ULG_ENC_RELU_EN
      if (v < 0) v = '0;
`endif
      d[c*8 +: 8] = v;
      if (c == 0 || v > mx) begin mx = v; a = 3'(c); end
    end
    return {last, a, d};
  endfunction

  function automatic logic [63:0] gen(input int i);
    logic [63:0] d;
    int v;
    d = '0;
    for (int c = 0; c < 8; c++) begin
      v = (c == (i + 2) % 8) ? 50 + i : c - 4;
      d[c*8 +: 8] = 8'(v);
    end
    return d;
  endfunction

  task automatic note_exp(input logic [63:0] px);
    exp_q.push_back(model(px, exp_idx == NP - 1));
    exp_idx = (exp_idx + 1) % NP;
  endtask

  task automatic send(input logic [63:0] px, input int budget,
                      output bit got);
    got = 1'b0;
    i_encoder_data_flat = px;
    i_encoder_req = 1'b1;
    for (int k = 0; k < budget && !got; k++) begin
      @(negedge clk);
      if (o_encoder_ack) got = 1'b1;
    end
    if (got) begin
      note_exp(px);
      i_encoder_req = 1'b0;
      @(negedge clk);
      @(negedge clk);
    end
  endtask

  task automatic wait_q(input string tag, input int n);
    int k;
    k = 0;
    while (out_q.size() < n && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_arrived"}, 128'(out_q.size() >= n), 128'(1));
  endtask

  task automatic drain(input string tag);
    wait_q(tag, exp_q.size());
    repeat (4) @(negedge clk);
    chk({tag, "_count"}, 128'(out_q.size()), 128'(exp_q.size()));
    while (out_q.size() > 0 && exp_q.size() > 0)
      chk({tag, "_entry"}, 128'(out_q.pop_front()),
          128'(exp_q.pop_front()));
    out_q.delete();
    exp_q.delete();
  endtask

  initial begin
    bit got;
    int a0;
    int f0;
    logic [63:0] p1;
    logic [63:0] p2;
    logic [63:0] p1_exp;
    logic [2:0]  p2_arg;

    p1 = 64'h0105FF000707FE03;
    p2 = 64'hFEF9FAFCFFF8FDFB;
`ifdef ULG_ENC_RELU_EN
    p1_exp = 64'h0105000007070003;
    p2_arg = 3'd0;
`else
    p1_exp = p1;
    p2_arg = 3'd3;
`endif

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_valid", 128'(o_out_valid), 128'(0));
    chk("rst_ack", 128'(o_encoder_ack), 128'(0));
    chk("rst_done", 128'(o_frame_done), 128'(0));
    chk("rst_data", 128'(o_out_data), 128'(0));
    chk("rst_arg", 128'(o_out_argmax), 128'(0));
    chk("rst_last", 128'(o_out_last), 128'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Single pixel with latency
    i_encoder_data_flat = p1;
    i_encoder_req = 1'b1;
    @(negedge clk);
    chk("s1_ack", 128'(o_encoder_ack), 128'(1));
    chk("s1_valid_early", 128'(o_out_valid), 128'(0));
    i_encoder_req = 1'b0;
    note_exp(p1);
    @(negedge clk);
    chk("s1_ack_low", 128'(o_encoder_ack), 128'(0));
    chk("s1_valid", 128'(o_out_valid), 128'(1));
    chk("s1_data", 128'(o_out_data), 128'(p1_exp));
    chk("s1_arg", 128'(o_out_argmax), 128'(2));
    chk("s1_last", 128'(o_out_last), 128'(0));
    repeat (2) @(negedge clk);

    // Request held high for five cycles
    a0 = ack_rise;
    i_encoder_data_flat = p2;
    i_encoder_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 1) begin
        chk("s2_valid", 128'(o_out_valid), 128'(1));
        chk("s2_arg", 128'(o_out_argmax), 128'(p2_arg));
      end
    end
    i_encoder_req = 1'b0;
    note_exp(p2);
    repeat (3) @(negedge clk);
    chk("s2_one_ack", 128'(ack_rise - a0), 128'(1));
    drain("s2");

    i_frame_start = 1'b1;
    @(negedge clk);
    i_frame_start = 1'b0;
    exp_idx = 0;

    // Backpressure across a full frame
    i_out_ready = 1'b0;
    a0 = ack_rise;
    f0 = fd_cnt;
    for (int i = 0; i < 4; i++) begin
      send(gen(i), 10, got);
      chk("s3_ack", 128'(got), 128'(1));
    end
    send(gen(4), 8, got);
    chk("s3_full_noack", 128'(got), 128'(0));
    chk("s3_four_acks", 128'(ack_rise - a0), 128'(4));
    chk("s3_full_valid", 128'(o_out_valid), 128'(1));
    i_out_ready = 1'b1;
    send(gen(4), 10, got);
    chk("s3_ack5", 128'(got), 128'(1));
    send(gen(5), 10, got);
    chk("s3_ack6", 128'(got), 128'(1));
    wait_q("s3", 6);
    repeat (3) @(negedge clk);
    chk("s3_last5", 128'(out_q[4][67]), 128'(0));
    chk("s3_last6", 128'(out_q[5][67]), 128'(1));
    chk("s3_frame_done", 128'(fd_cnt - f0), 128'(1));
    drain("s3");

    send(gen(6), 10, got);
    chk("s3_ack7", 128'(got), 128'(1));
    wait_q("s3w", 1);
    chk("s3_wrap_last", 128'(out_q[0][67]), 128'(0));
    drain("s3w");

    // Clock enable low mid-handshake
    a0 = ack_rise;
    i_encoder_data_flat = gen(7);
    i_encoder_req = 1'b1;
    @(negedge clk);
    chk("s4_ack", 128'(o_encoder_ack), 128'(1));
    i_clk_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("s4_ack_frozen", 128'(o_encoder_ack), 128'(1));
      chk("s4_valid_frozen", 128'(o_out_valid), 128'(0));
    end
    i_clk_en = 1'b1;
    note_exp(gen(7));
    @(negedge clk);
    chk("s4_ack_low", 128'(o_encoder_ack), 128'(0));
    chk("s4_valid", 128'(o_out_valid), 128'(1));
    repeat (3) @(negedge clk);
    i_encoder_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("s4_one_ack", 128'(ack_rise - a0), 128'(1));
    drain("s4");

    // Reset with two entries held
    i_out_ready = 1'b0;
    send(gen(8), 10, got);
    send(gen(9), 10, got);
    repeat (2) @(negedge clk);
    chk("s5_valid_pre", 128'(o_out_valid), 128'(1));
    rst_n = 1'b0;
    #1;
    chk("s5_valid_rst", 128'(o_out_valid), 128'(0));
    chk("s5_ack_rst", 128'(o_encoder_ack), 128'(0));
    chk("s5_data_rst", 128'(o_out_data), 128'(0));
    out_q.delete();
    exp_q.delete();
    exp_idx = 0;
    @(negedge clk);
    rst_n = 1'b1;
    i_out_ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < NP; i++) begin
      send(gen(10 + i), 10, got);
      chk("s5_ack", 128'(got), 128'(1));
    end
    wait_q("s5", NP);
    chk("s5_first_last", 128'(out_q[0][67]), 128'(0));
    chk("s5_sixth_last", 128'(out_q[NP-1][67]), 128'(1));
    drain("s5");

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule
